nonce_search_ctrl: RTL and testbench
====================================

// Module: nonce_search_ctrl
// PURPOSE
//  Sequences the SHA-256 hash core for a Bitcoin nonce search inside the miner top level.
//  - Latches the 608-bit header and 256-bit target from rx_data.
//  - Issues one hash job per nonce and compares each digest against the target.
//  - Reports the first winning {nonce, hash} on tx_data with a send_data pulse,
//    or signals exhaustion when the nonce range ends without a winner.
// PARAMETERS
//  NONCE_START  32'h0000_0000  first nonce tried after each data_ready
//  NONCE_LAST   32'hFFFF_FFFF  last nonce tried; search ends after it, never wraps
// PORTS
//  clk          in   1    system clock, all state updates on posedge
//  n_rst        in   1    asynchronous active-low reset
//  data_ready   in   1    new job request; honoured only in IDLE
//  rx_data      in   864  {header[607:0], target[255:0]}
//  abort        in   1    cancel the current search; honoured in any non-IDLE state
//  hash_start   out  1    one-cycle pulse to the hash core, asserted in ISSUE
//  hash_block   out  640  {header_q, nonce_q}; stable from ISSUE until the core's hash_done
//  hash_done    in   1    core completion strobe; honoured only in WAIT
//  hash_result  in   256  digest; valid in the cycle hash_done is high
//  send_data    out  1    one-cycle pulse; tx_data holds a winner
//  tx_data      out  288  {nonce[31:0], hash[255:0]}; holds until the next winner
//  busy         out  1    high in every state except IDLE
//  exhausted    out  1    one-cycle pulse; range ended with no winner
// BEHAVIOUR
//  Reset (n_rst=0, async): state=IDLE; outputs low/zero (send_data, hash_start, tx_data,
//    busy, exhausted); header_q, target_q, nonce_q and hash_q cleared.
//  FSM states: IDLE, ISSUE, WAIT, CHECK.
//  IDLE:
//    - data_ready=1 at a posedge: latch header_q<=rx_data[863:256], target_q<=rx_data[255:0],
//      nonce_q<=NONCE_START; go to ISSUE.
//  ISSUE:
//    - hash_start=1 for exactly this cycle; go to WAIT.
//  WAIT:
//    - hash_done=1: hash_q<=hash_result; go to CHECK. Otherwise stay; there is no timeout.
//  CHECK (one cycle, registered compare on hash_q):
//    - Win (hash_q < target_q, unsigned 256-bit, strict): tx_data<={nonce_q,hash_q};
//      send_data=1 in the next cycle; go to IDLE.
//    - Else if nonce_q==NONCE_LAST: exhausted=1 in the next cycle; go to IDLE.
//    - Else: nonce_q<=nonce_q+1; go to ISSUE.
//  Equality (hash == target) is NOT a win.
//  Latency:
//    - data_ready sampled at edge k -> hash_start high during cycle k+1.
//    - Per-nonce cost = 2 + core latency (cycles).
//    - Win in CHECK at edge m -> send_data high during cycle m+1, the same cycle busy drops.
//  abort:
//    - Outside IDLE: go to IDLE at the next edge; no send_data, no exhausted; tx_data unchanged.
//    - abort has priority over hash_done and data_ready in the same cycle.
//  Ignored inputs:
//    - data_ready while busy has no effect on the search.
//    - rx_data changes after latching have no effect on the search.
//    - A late hash_done arriving in IDLE or ISSUE is ignored.
//  data_ready and abort both high in IDLE: the job starts (abort applies only outside IDLE).
//  nonce_q never wraps. If NONCE_START==NONCE_LAST, exactly one job is issued.
//  Reset mid-search: immediate return to IDLE with all outputs cleared.
// TESTING (bench uses a hash-core model: hash_done 3 cycles after hash_start,
//          hash_result taken from a per-nonce table)
//  1 Assert reset mid-WAIT -> send_data, tx_data, busy, exhausted and hash_start all 0
//    immediately; FSM back in IDLE.
//  2 Drive the miner test header with target F000..0; model returns 1000..0 for nonce 0
//    -> hash_start 1 cycle after data_ready; exactly one send_data pulse;
//       tx_data={32'h0, 256'h1000..0}.
//  3 Model returns a hash equal to target for nonces 0 and 1, and 0..01 for nonce 2
//    -> 3 hash_start pulses; tx_data[287:256]=32'h2.
//  4 NONCE_START=FFFFFFFE, NONCE_LAST=FFFFFFFF, model never wins
//    -> exactly 2 hash_starts; one exhausted pulse; no send_data; nonce never reaches 0.
//  5 abort in WAIT, then hash_done 1 cycle later
//    -> busy low after 1 cycle; no send_data; tx_data unchanged;
//       next data_ready restarts at NONCE_START.
//  6 data_ready pulsed with new rx_data during the search
//    -> hash_block keeps the original header; the result reflects the first job only.

Source files
------------

// File: rtl/nonce_search_ctrl_if.sv
// Handshake bundle between the miner top level, the SHA-256 core and the nonce search sequencer.
interface nonce_search_ctrl_if;
  logic         data_ready;
  logic [863:0] rx_data;
  logic         abort;
  logic         hash_start;
  logic [639:0] hash_block;
  logic         hash_done;
  logic [255:0] hash_result;
  logic         send_data;
  logic [287:0] tx_data;
  logic         busy;
  logic         exhausted;

  modport slave (
    input  data_ready, rx_data, abort, hash_done, hash_result,
    output hash_start, hash_block, send_data, tx_data, busy, exhausted
  );

  modport master (
    output data_ready, rx_data, abort, hash_done, hash_result,
    input  hash_start, hash_block, send_data, tx_data, busy, exhausted
  );
endinterface

// File: rtl/nonce_search_ctrl.sv
// Walks the nonce range, issuing one hash job per nonce and reporting the first digest
// strictly below the target, or an exhaustion pulse when the range runs out.
module nonce_search_ctrl #(
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter logic [31:0] NONCE_LAST  = 32'hFFFF_FFFF
) (
  input logic                   clk,
  input logic                   n_rst,
  nonce_search_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} state_t;

  state_t         r_state;
  logic [607:0]   r_header;
  logic [255:0]   r_target;
  logic [31:0]    r_nonce;
  logic [255:0]   r_hash;
  logic [287:0]   r_tx;
  logic           r_send;
  logic           r_start;
  logic           r_busy;
  logic           r_exh;
  logic           w_win;

  // Equality with the target does not count as a win.
  assign w_win = (r_hash < r_target);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_header <= '0;
      r_target <= '0;
      r_nonce  <= '0;
      r_hash   <= '0;
      r_tx     <= '0;
      r_send   <= 1'b0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_exh    <= 1'b0;
    end else begin
      r_send  <= 1'b0;
      r_start <= 1'b0;
      r_exh   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.data_ready) begin
            r_header <= bus.rx_data[863:256];
            r_target <= bus.rx_data[255:0];
            r_nonce  <= NONCE_START;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (bus.hash_done) begin
            r_hash  <= bus.hash_result;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_win) begin
            r_tx    <= {r_nonce, r_hash};
            r_send  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_nonce == NONCE_LAST) begin
            // Compare before incrementing so the nonce never wraps past the end.
            r_exh   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_nonce <= r_nonce + 32'd1;
            r_start <= 1'b1;
            r_state <= ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.hash_start = r_start;
  assign bus.hash_block = {r_header, r_nonce};
  assign bus.send_data  = r_send;
  assign bus.tx_data    = r_tx;
  assign bus.busy       = r_busy;
  assign bus.exhausted  = r_exh;
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl with a 3-cycle hash-core model per instance.
module tb_nonce_search_ctrl;
  localparam logic [255:0] T_F = {4'hF, 252'h0};
  localparam logic [255:0] H_1 = {4'h1, 252'h0};
  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [607:0] HDR1 = {19{32'hA5A5_0001}};
  localparam logic [607:0] HDR2 = {19{32'h5A5A_0002}};

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;
  int   mode;

  nonce_search_ctrl_if ifa ();
  nonce_search_ctrl_if ifb ();

  nonce_search_ctrl dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
  nonce_search_ctrl #(.NONCE_START(32'hFFFF_FFFE), .NONCE_LAST(32'hFFFF_FFFF)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] hash_a(input logic [31:0] n);
    logic [255:0] h;
    h = ONES;
    case (mode)
      2: if (n == 32'd0) h = H_1;
      3: begin
        if (n < 32'd2) h = T_F;
        else if (n == 32'd2) h = 256'd1;
      end
      5: h = 256'd1;
      6: if (n == 32'd1) h = 256'd5;
      default: h = ONES;
    endcase
    return h;
  endfunction

  // Hash core models and pulse monitors
  int ca, cb;
  logic [31:0] na;
  int n_start, n_send, n_exh;
  int nb_start, nb_send, nb_exh, nb_wrap;
  logic [639:0] last_blk, first_blk_b;

  initial begin
    ca = 0; cb = 0; na = '0;
    n_start = 0; n_send = 0; n_exh = 0;
    nb_start = 0; nb_send = 0; nb_exh = 0; nb_wrap = 0;
    last_blk = '0; first_blk_b = '0;
  end

  always @(posedge clk) begin
    if (ifa.hash_start) begin
      ca = 3; na = ifa.hash_block[31:0]; n_start = n_start + 1; last_blk = ifa.hash_block;
    end else if (ca > 0) ca = ca - 1;
    ifa.hash_done   <= (ca == 1);
    ifa.hash_result <= hash_a(na);
    if (ifa.send_data) n_send = n_send + 1;
    if (ifa.exhausted) n_exh = n_exh + 1;
  end

  always @(posedge clk) begin
    if (ifb.hash_start) begin
      cb = 3; nb_start = nb_start + 1;
      if (nb_start == 1) first_blk_b = ifb.hash_block;
      if (ifb.hash_block[31:0] == 32'd0) nb_wrap = nb_wrap + 1;
    end else if (cb > 0) cb = cb - 1;
    ifb.hash_done   <= (cb == 1);
    ifb.hash_result <= ONES;
    if (ifb.send_data) nb_send = nb_send + 1;
    if (ifb.exhausted) nb_exh = nb_exh + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input bit sel_b, input int lim, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (!(sel_b ? ifb.busy : ifa.busy)) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic start_a(input logic [607:0] hdr, input logic [255:0] tgt);
    ifa.rx_data    = {hdr, tgt};
    ifa.data_ready = 1'b1;
    tick(1);
    ifa.data_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({ifa.send_data, ifa.hash_start, ifa.busy, ifa.exhausted} !== 4'b0 || ifa.tx_data !== '0) begin
      errors++;
      $display("FAIL reset_state: flags=%b tx=%h expected all zero",
               {ifa.send_data, ifa.hash_start, ifa.busy, ifa.exhausted}, ifa.tx_data);
    end
    checks++;
    if (ifa.hash_block !== '0) begin
      errors++; $display("FAIL reset_block: got %h expected 0", ifa.hash_block);
    end
    n_rst = 1'b1;
    tick(2);
    // Reset while waiting on the core
    mode = 5;
    start_a(HDR1, T_F);
    tick(1);
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre_busy: got %b expected 1", ifa.busy);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({ifa.send_data, ifa.hash_start, ifa.busy, ifa.exhausted} !== 4'b0 || ifa.tx_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: flags=%b tx=%h expected all zero",
               {ifa.send_data, ifa.hash_start, ifa.busy, ifa.exhausted}, ifa.tx_data);
    end
    tick(1);
    n_rst = 1'b1;
    n_send = 0; n_start = 0;
    tick(6);
    checks++;
    if (ifa.busy !== 1'b0 || n_send != 0 || n_start != 0) begin
      errors++;
      $display("FAIL reset_late_done: busy=%b sends=%0d starts=%0d expected 0/0/0",
               ifa.busy, n_send, n_start);
    end
  endtask

  task automatic test_win;
    bit to;
    mode = 2;
    n_start = 0; n_send = 0;
    ifa.rx_data    = {HDR1, T_F};
    ifa.data_ready = 1'b1;
    tick(1);
    ifa.data_ready = 1'b0;
    checks++;
    if (ifa.hash_start !== 1'b1 || ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL win_start_latency: hash_start=%b busy=%b expected 1/1", ifa.hash_start, ifa.busy);
    end
    checks++;
    if (ifa.hash_block !== {HDR1, 32'd0}) begin
      errors++; $display("FAIL win_block: got %h expected %h", ifa.hash_block, {HDR1, 32'd0});
    end
    wait_idle(1'b0, 40, to);
    checks++;
    if (to || ifa.send_data !== 1'b1) begin
      errors++; $display("FAIL win_send_with_idle: timeout=%b send=%b expected 0/1", to, ifa.send_data);
    end
    tick(3);
    checks++;
    if (ifa.tx_data !== {32'd0, H_1} || n_send != 1 || n_start != 1) begin
      errors++;
      $display("FAIL win_result: tx=%h sends=%0d starts=%0d expected %h/1/1",
               ifa.tx_data, n_send, n_start, {32'd0, H_1});
    end
  endtask

  task automatic test_equal_not_win;
    bit to;
    mode = 3;
    n_start = 0; n_send = 0;
    start_a(HDR1, T_F);
    wait_idle(1'b0, 80, to);
    tick(2);
    checks++;
    if (to || n_start != 3 || n_send != 1) begin
      errors++;
      $display("FAIL equal_counts: timeout=%b starts=%0d sends=%0d expected 0/3/1", to, n_start, n_send);
    end
    checks++;
    if (ifa.tx_data !== {32'd2, 256'd1}) begin
      errors++; $display("FAIL equal_tx: got %h expected %h", ifa.tx_data, {32'd2, 256'd1});
    end
  endtask

  task automatic test_exhaust;
    bit to;
    int hi;
    nb_start = 0; nb_send = 0; nb_exh = 0; nb_wrap = 0;
    ifb.rx_data    = {HDR1, 256'd0};
    ifb.data_ready = 1'b1;
    tick(1);
    ifb.data_ready = 1'b0;
    wait_idle(1'b1, 80, to);
    hi = 0;
    if (ifb.exhausted) hi++;
    tick(1);
    if (ifb.exhausted) hi++;
    tick(4);
    checks++;
    if (to || nb_start != 2 || nb_exh != 1 || nb_send != 0) begin
      errors++;
      $display("FAIL exhaust_counts: timeout=%b starts=%0d exh=%0d sends=%0d expected 0/2/1/0",
               to, nb_start, nb_exh, nb_send);
    end
    checks++;
    if (hi != 1 || nb_wrap != 0 || first_blk_b[31:0] !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL exhaust_bounds: pulse_cycles=%0d wraps=%0d first_nonce=%h expected 1/0/fffffffe",
               hi, nb_wrap, first_blk_b[31:0]);
    end
  endtask

  task automatic test_abort;
    bit to;
    logic [287:0] tx_before;
    mode = 5;
    n_send = 0; n_start = 0;
    tx_before = ifa.tx_data;
    start_a(HDR2, T_F);
    tick(1);
    ifa.abort = 1'b1;
    tick(1);
    ifa.abort = 1'b0;
    checks++;
    if (ifa.busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy: got %b expected 0", ifa.busy);
    end
    tick(6);
    checks++;
    if (n_send != 0 || ifa.tx_data !== tx_before || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: sends=%0d tx=%h busy=%b expected 0/%h/0",
               n_send, ifa.tx_data, ifa.busy, tx_before);
    end
    start_a(HDR2, T_F);
    checks++;
    if (ifa.hash_start !== 1'b1 || ifa.hash_block[31:0] !== 32'd0) begin
      errors++;
      $display("FAIL abort_restart: hash_start=%b nonce=%h expected 1/0", ifa.hash_start, ifa.hash_block[31:0]);
    end
    wait_idle(1'b0, 40, to);
    tick(1);
    checks++;
    if (to || ifa.tx_data !== {32'd0, 256'd1} || n_send != 1) begin
      errors++;
      $display("FAIL abort_rerun: timeout=%b tx=%h sends=%0d expected 0/%h/1",
               to, ifa.tx_data, n_send, {32'd0, 256'd1});
    end
  endtask

  task automatic test_busy_ignore;
    bit to;
    mode = 6;
    n_start = 0; n_send = 0;
    start_a(HDR1, T_F);
    tick(2);
    ifa.rx_data    = {HDR2, 256'd0};
    ifa.data_ready = 1'b1;
    tick(1);
    ifa.data_ready = 1'b0;
    wait_idle(1'b0, 60, to);
    tick(2);
    checks++;
    if (to || n_start != 2 || n_send != 1) begin
      errors++;
      $display("FAIL busy_counts: timeout=%b starts=%0d sends=%0d expected 0/2/1", to, n_start, n_send);
    end
    checks++;
    if (last_blk !== {HDR1, 32'd1}) begin
      errors++; $display("FAIL busy_header: got %h expected %h", last_blk, {HDR1, 32'd1});
    end
    checks++;
    if (ifa.tx_data !== {32'd1, 256'd5}) begin
      errors++; $display("FAIL busy_tx: got %h expected %h", ifa.tx_data, {32'd1, 256'd5});
    end
  endtask

  initial begin
    checks = 0; errors = 0; mode = 0;
    n_rst = 1'b0;
    ifa.data_ready = 1'b0; ifa.rx_data = '0; ifa.abort = 1'b0;
    ifb.data_ready = 1'b0; ifb.rx_data = '0; ifb.abort = 1'b0;
    tick(2);
    test_reset;
    test_win;
    test_equal_not_win;
    test_exhaust;
    test_abort;
    test_busy_ignore;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
